// File: rtl/mc_datapath_p_if.sv
// Instruction and data memory bus of the multi-cycle datapath.
// The master side is the datapath; the slave side is the memory system.
interface mc_datapath_p_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 16
);
    logic             imem_req;
    logic [AW-1:0]    imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             dmem_req;
    logic             dmem_we;
    logic [AW-1:0]    dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_ack;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mc_datapath_p.sv
// Multi-cycle load/store datapath: FETCH, DECODE, EXEC, MEM, WB, HALT.
// Register 0 and any index at or above NREG read as zero and ignore writes.
module mc_datapath_p #(
    parameter int WIDTH = 32,
    parameter int NREG  = 16,
    parameter int AW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    mc_datapath_p_if.master     bus,
    input  logic [3:0]          dbg_sel,
    output logic [WIDTH-1:0]    dbg_val,
    output logic [AW-1:0]       pc,
    output logic                halted
);

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_LD   = 6'd5;
    localparam logic [5:0] OP_ST   = 6'd6;
    localparam logic [5:0] OP_BEQ  = 6'd7;
    localparam logic [5:0] OP_HALT = 6'd8;

    // The immediate is kept wide enough to serve both data and PC arithmetic.
    localparam int IW = (WIDTH > AW) ? WIDTH : AW;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_pc;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_imm;
    logic [WIDTH-1:0] r_aluOut;
    logic [WIDTH-1:0] r_lmd;
    logic [WIDTH-1:0] r_regs [1:NREG-1];

    logic [5:0]       w_op;
    logic [3:0]       w_rd;
    logic [3:0]       w_rs1;
    logic [3:0]       w_rs2;
    logic [IW-1:0]    w_immExt;
    logic [WIDTH-1:0] w_immData;
    logic [AW-1:0]    w_immPc;
    logic [AW-1:0]    w_pcNext;
    logic [AW-1:0]    w_pcBranch;
    logic [WIDTH-1:0] w_rs1Val;
    logic [WIDTH-1:0] w_rs2Val;
    logic [WIDTH-1:0] w_aluRes;
    logic [WIDTH-1:0] w_wbData;
    logic             w_inMem;

    assign w_op       = r_ir[31:26];
    assign w_rd       = r_ir[25:22];
    assign w_rs1      = r_ir[21:18];
    assign w_rs2      = r_ir[17:14];
    assign w_immExt   = IW'($signed(r_ir[13:0]));
    assign w_immData  = r_imm[WIDTH-1:0];
    assign w_immPc    = r_imm[AW-1:0];
    assign w_pcNext   = r_pc + AW'(1);
    assign w_pcBranch = r_pc + AW'(1) + w_immPc;
    assign w_wbData   = (w_op == OP_LD) ? r_lmd : r_aluOut;

    // Register file read ports; r0 and out-of-range indices fall through to zero.
    always_comb begin
        w_rs1Val = '0;
        w_rs2Val = '0;
        dbg_val  = '0;
        for (int k = 1; k < NREG; k++) begin
            if (w_rs1 == 4'(k)) begin
                w_rs1Val = r_regs[k];
            end
            if (w_rs2 == 4'(k)) begin
                w_rs2Val = r_regs[k];
            end
            if (dbg_sel == 4'(k)) begin
                dbg_val = r_regs[k];
            end
        end
    end

    // Loads, stores and ADDI all compute A + IMM, so that is the default.
    always_comb begin
        w_aluRes = r_a + w_immData;
        case (w_op)
            OP_ADD:  w_aluRes = r_a + r_b;
            OP_SUB:  w_aluRes = r_a - r_b;
            OP_AND:  w_aluRes = r_a & r_b;
            OP_OR:   w_aluRes = r_a | r_b;
            default: w_aluRes = r_a + w_immData;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_aluOut <= '0;
            r_lmd    <= '0;
            for (int k = 1; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir    <= bus.imem_rdata;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_a     <= w_rs1Val;
                    r_b     <= w_rs2Val;
                    r_imm   <= w_immExt;
                    r_state <= (w_op == OP_HALT) ? HALT : EXEC;
                end
                EXEC: begin
                    case (w_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            r_aluOut <= w_aluRes;
                            r_state  <= WB;
                        end
                        OP_LD, OP_ST: begin
                            r_aluOut <= w_aluRes;
                            r_state  <= MEM;
                        end
                        OP_BEQ: begin
                            r_pc    <= (r_a == r_b) ? w_pcBranch : w_pcNext;
                            r_state <= FETCH;
                        end
                        default: begin
                            r_pc    <= w_pcNext;
                            r_state <= FETCH;
                        end
                    endcase
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        if (w_op == OP_ST) begin
                            r_pc    <= w_pcNext;
                            r_state <= FETCH;
                        end else begin
                            r_lmd   <= bus.dmem_rdata;
                            r_state <= WB;
                        end
                    end
                end
                WB: begin
                    for (int k = 1; k < NREG; k++) begin
                        if (w_rd == 4'(k)) begin
                            r_regs[k] <= w_wbData;
                        end
                    end
                    r_pc    <= w_pcNext;
                    r_state <= FETCH;
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // Fetch is gated by rst so the very first post-reset cycle can request.
    assign w_inMem        = (r_state == MEM);
    assign bus.imem_req   = (r_state == FETCH) && !rst;
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = w_inMem;
    assign bus.dmem_we    = w_inMem && (w_op == OP_ST);
    assign bus.dmem_addr  = w_inMem ? AW'(r_aluOut) : '0;
    assign bus.dmem_wdata = w_inMem ? r_b : '0;
    assign pc             = r_pc;
    assign halted         = (r_state == HALT);

endmodule

// File: tb/tb_mc_datapath_p.sv
// Directed bench for mc_datapath_p: a 32-bit/16-register instance with a
// wait-state data memory, plus an 8-bit/4-register instance for wrap and range.
module tb_mc_datapath_p;

    logic        clk;
    logic        rst;
    logic [3:0]  dbgSel0;
    logic [3:0]  dbgSel1;
    logic [31:0] dbgVal0;
    logic [7:0]  dbgVal1;
    logic [15:0] pc0;
    logic [15:0] pc1;
    logic        halted0;
    logic        halted1;

    logic [31:0] prog0 [32];
    logic [31:0] prog1 [32];
    logic [31:0] dmem0 [256];
    logic [7:0]  dmemDelay;
    logic [7:0]  waitCnt0;
    logic        forceAck;

    int cyc;
    int total;
    int bad;
    int fetch0 [32];
    int fetch1 [32];
    int loopCnt;
    int maxAddr0;
    int txCount;
    int unstable;
    logic        prevReq;
    logic        txWe   [2];
    logic [15:0] txAddr [2];
    logic [31:0] txData [2];
    logic        curWe;
    logic [15:0] curAddr;
    logic [31:0] curData;

    mc_datapath_p_if #(.WIDTH(32), .AW(16)) bus0 ();
    mc_datapath_p_if #(.WIDTH(8),  .AW(16)) bus1 ();

    mc_datapath_p #(.WIDTH(32), .NREG(16), .AW(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .dbg_sel(dbgSel0),
        .dbg_val(dbgVal0), .pc(pc0), .halted(halted0)
    );

    mc_datapath_p #(.WIDTH(8), .NREG(4), .AW(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .dbg_sel(dbgSel1),
        .dbg_val(dbgVal1), .pc(pc1), .halted(halted1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait instruction memories; out-of-range fetches return a NOP.
    assign bus0.imem_ack   = bus0.imem_req;
    assign bus0.imem_rdata = (bus0.imem_addr < 16'd32) ? prog0[bus0.imem_addr[4:0]] : 32'hFC00_0000;
    assign bus1.imem_ack   = bus1.imem_req;
    assign bus1.imem_rdata = (bus1.imem_addr < 16'd32) ? prog1[bus1.imem_addr[4:0]] : 32'hFC00_0000;

    // Data memory for dut0 acknowledges after dmemDelay wait cycles.
    assign bus0.dmem_ack   = forceAck | (bus0.dmem_req && (waitCnt0 == dmemDelay));
    assign bus0.dmem_rdata = dmem0[bus0.dmem_addr[7:0]];
    assign bus1.dmem_ack   = bus1.dmem_req;
    assign bus1.dmem_rdata = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            cyc      <= 0;
            waitCnt0 <= 8'd0;
            for (int k = 0; k < 256; k++) begin
                dmem0[k] <= (k == 32) ? 32'h77 : 32'h0;
            end
        end else begin
            cyc <= cyc + 1;
            if (!bus0.dmem_req || bus0.dmem_ack) begin
                waitCnt0 <= 8'd0;
            end else begin
                waitCnt0 <= waitCnt0 + 8'd1;
            end
            if (bus0.dmem_req && bus0.dmem_ack && bus0.dmem_we) begin
                dmem0[bus0.dmem_addr[7:0]] <= bus0.dmem_wdata;
            end
        end
    end

    // Monitor: first fetch cycle per address, loop fetches, data transactions.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                fetch0[k] = -1;
                fetch1[k] = -1;
            end
            loopCnt  = 0;
            maxAddr0 = 0;
            txCount  = 0;
            unstable = 0;
            prevReq  = 1'b0;
            for (int k = 0; k < 2; k++) begin
                txWe[k]   = 1'b0;
                txAddr[k] = 16'h0;
                txData[k] = 32'h0;
            end
        end else begin
            if (bus0.imem_req) begin
                if (bus0.imem_addr < 16'd32 && fetch0[bus0.imem_addr[4:0]] == -1) begin
                    fetch0[bus0.imem_addr[4:0]] = cyc;
                end
                if (bus0.imem_addr == 16'd4) begin
                    loopCnt++;
                end
                if (int'(bus0.imem_addr) > maxAddr0) begin
                    maxAddr0 = int'(bus0.imem_addr);
                end
            end
            if (bus1.imem_req && bus1.imem_addr < 16'd32 && fetch1[bus1.imem_addr[4:0]] == -1) begin
                fetch1[bus1.imem_addr[4:0]] = cyc;
            end
            if (bus0.dmem_req) begin
                if (!prevReq) begin
                    curWe   = bus0.dmem_we;
                    curAddr = bus0.dmem_addr;
                    curData = bus0.dmem_wdata;
                    if (txCount < 2) begin
                        txWe[txCount]   = curWe;
                        txAddr[txCount] = curAddr;
                        txData[txCount] = curData;
                    end
                    txCount++;
                end else if (bus0.dmem_we != curWe || bus0.dmem_addr != curAddr ||
                             (curWe && bus0.dmem_wdata != curData)) begin
                    unstable++;
                end
            end
            prevReq = bus0.dmem_req;
        end
    end

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        logic [5:0]  o;
        logic [3:0]  d;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [13:0] im;
        o  = op[5:0];
        d  = rd[3:0];
        s1 = rs1[3:0];
        s2 = rs2[3:0];
        im = imm[13:0];
        return {o, d, s1, s2, im};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkReg0(input string tag, input int sel, input logic [31:0] expected);
        dbgSel0 = sel[3:0];
        #1;
        checkOutput(tag, {32'h0, dbgVal0}, {32'h0, expected});
    endtask

    task automatic checkReg1(input string tag, input int sel, input logic [7:0] expected);
        dbgSel1 = sel[3:0];
        #1;
        checkOutput(tag, {56'h0, dbgVal1}, {56'h0, expected});
    endtask

    task automatic enterReset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 32; k++) begin
            prog0[k] = enc(63, 0, 0, 0, 0);
            prog1[k] = enc(63, 0, 0, 0, 0);
        end
    endtask

    // Release reset just after an edge and confirm the immediate fetch request.
    task automatic applyStimulus();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("firstReq", {63'h0, bus0.imem_req}, 64'h1);
        checkOutput("firstAddr", {48'h0, bus0.imem_addr}, 64'h0);
    endtask

    task automatic waitHalted(input int which, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && halted0) || (which == 1 && halted1)) begin
                break;
            end
        end
        checkOutput(which == 0 ? "halted0" : "halted1",
                    {63'h0, (which == 0) ? halted0 : halted1}, 64'h1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        total     = 0;
        bad       = 0;
        dbgSel0   = 4'd0;
        dbgSel1   = 4'd0;
        dmemDelay = 8'd0;
        forceAck  = 1'b0;

        // Phase 1: short ALU program on dut0; wrap and register range on dut1.
        enterReset();
        prog0[0] = enc(4, 1, 0, 0, 5);
        prog0[1] = enc(4, 2, 0, 0, 7);
        prog0[2] = enc(0, 3, 1, 2, 0);
        prog0[3] = enc(8, 0, 0, 0, 0);
        prog1[0] = enc(4, 1, 0, 0, -1);
        prog1[1] = enc(4, 1, 1, 0, 2);
        prog1[2] = enc(4, 0, 0, 0, 9);
        prog1[3] = enc(4, 2, 0, 0, 3);
        prog1[4] = enc(7, 0, 1, 2, 10);
        prog1[5] = enc(4, 3, 0, 0, 'h22);
        prog1[6] = enc(4, 7, 0, 0, 'h55);
        prog1[7] = enc(8, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rstPc", {48'h0, pc0}, 64'h0);
        checkOutput("rstHalted", {63'h0, halted0}, 64'h0);
        checkOutput("rstImemReq", {63'h0, bus0.imem_req}, 64'h0);
        checkOutput("rstDmemReq", {63'h0, bus0.dmem_req}, 64'h0);
        applyStimulus();
        waitHalted(0, 200);
        checkReg0("p1_r1", 1, 32'd5);
        checkReg0("p1_r2", 2, 32'd7);
        checkReg0("p1_r3", 3, 32'd12);
        checkOutput("p1_pc", {48'h0, pc0}, 64'd3);
        checkOutput("aluLatency", 64'(fetch0[1] - fetch0[0]), 64'd4);
        checkOutput("haltFetchCycle", 64'(fetch0[3]), 64'd12);
        repeat (5) @(negedge clk);
        checkOutput("haltPcFrozen", {48'h0, pc0}, 64'd3);
        checkOutput("haltNoImemReq", {63'h0, bus0.imem_req}, 64'h0);
        checkOutput("haltStays", {63'h0, halted0}, 64'h1);
        waitHalted(1, 200);
        checkReg1("w8_r1wrap", 1, 8'h01);
        checkReg1("w8_r0zero", 0, 8'h00);
        checkReg1("w8_r2", 2, 8'h03);
        checkReg1("w8_r3", 3, 8'h22);
        checkReg1("w8_dbg7", 7, 8'h00);
        checkReg1("w8_dbg4", 4, 8'h00);
        checkOutput("w8_pc", {48'h0, pc1}, 64'd7);
        checkOutput("beqNotTakenLat", 64'(fetch1[5] - fetch1[4]), 64'd3);

        // Phase 2: store then load with three data-memory wait cycles.
        enterReset();
        prog0[0]  = enc(4, 1, 0, 0, 5);
        prog0[1]  = enc(4, 2, 0, 0, 7);
        prog0[2]  = enc(0, 3, 1, 2, 0);
        prog0[3]  = enc(6, 0, 0, 3, 'h10);
        prog0[4]  = enc(5, 4, 0, 0, 'h10);
        prog0[5]  = enc(1, 5, 1, 2, 0);
        prog0[6]  = enc(2, 6, 1, 2, 0);
        prog0[7]  = enc(3, 7, 1, 2, 0);
        prog0[8]  = enc(9, 0, 0, 0, 0);
        prog0[9]  = enc(7, 0, 1, 2, 5);
        prog0[10] = enc(8, 0, 0, 0, 0);
        dmemDelay = 8'd3;
        applyStimulus();
        waitHalted(0, 300);
        checkReg0("p2_r4load", 4, 32'd12);
        checkReg0("p2_r5sub", 5, 32'hFFFF_FFFE);
        checkReg0("p2_r6and", 6, 32'd5);
        checkReg0("p2_r7or", 7, 32'd7);
        checkOutput("p2_pc", {48'h0, pc0}, 64'd10);
        checkOutput("txCount", 64'(txCount), 64'd2);
        checkOutput("stWe", {63'h0, txWe[0]}, 64'h1);
        checkOutput("stAddr", {48'h0, txAddr[0]}, 64'h10);
        checkOutput("stData", {32'h0, txData[0]}, 64'd12);
        checkOutput("ldWe", {63'h0, txWe[1]}, 64'h0);
        checkOutput("ldAddr", {48'h0, txAddr[1]}, 64'h10);
        checkOutput("dmemUnstable", 64'(unstable), 64'd0);
        checkOutput("stLatency", 64'(fetch0[4] - fetch0[3]), 64'd7);
        checkOutput("ldLatency", 64'(fetch0[5] - fetch0[4]), 64'd8);
        checkOutput("nopLatency", 64'(fetch0[9] - fetch0[8]), 64'd3);
        checkOutput("haltFetch2", 64'(fetch0[10]), 64'd45);

        // Phase 3: BEQ r1,r1,-1 at address 4 spins in place.
        enterReset();
        prog0[0] = enc(4, 1, 0, 0, 3);
        prog0[1] = enc(4, 2, 0, 0, 4);
        prog0[2] = enc(9, 0, 0, 0, 0);
        prog0[3] = enc(9, 0, 0, 0, 0);
        prog0[4] = enc(7, 0, 1, 1, -1);
        dmemDelay = 8'd0;
        applyStimulus();
        repeat (40) @(negedge clk);
        checkOutput("loopPc", {48'h0, pc0}, 64'd4);
        checkOutput("loopMaxAddr", 64'(maxAddr0), 64'd4);
        checkOutput("loopFirstFetch", 64'(fetch0[4]), 64'd14);
        checkOutput("loopRepeats", {63'h0, loopCnt >= 5}, 64'h1);
        checkOutput("loopNotHalted", {63'h0, halted0}, 64'h0);

        // Phase 4: reset while a load is stalled in MEM, with a stray ack after.
        enterReset();
        prog0[0] = enc(4, 1, 0, 0, 9);
        prog0[1] = enc(5, 5, 0, 0, 'h20);
        prog0[2] = enc(8, 0, 0, 0, 0);
        dmemDelay = 8'd200;
        applyStimulus();
        for (int i = 0; i < 50; i++) begin
            if (bus0.dmem_req) begin
                break;
            end
            @(negedge clk);
        end
        checkOutput("ldPending", {63'h0, bus0.dmem_req}, 64'h1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midRstDmemReq", {63'h0, bus0.dmem_req}, 64'h0);
        checkOutput("midRstPc", {48'h0, pc0}, 64'h0);
        @(posedge clk);
        #1 forceAck = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("relImemReq", {63'h0, bus0.imem_req}, 64'h1);
        checkOutput("relImemAddr", {48'h0, bus0.imem_addr}, 64'h0);
        checkOutput("relDmemReq", {63'h0, bus0.dmem_req}, 64'h0);
        checkReg0("relR5", 5, 32'h0);
        @(posedge clk);
        #1 forceAck = 1'b0;
        dmemDelay = 8'd0;
        waitHalted(0, 100);
        checkReg0("p4_r1", 1, 32'd9);
        checkReg0("p4_r5", 5, 32'h77);
        checkOutput("p4_pc", {48'h0, pc0}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_datapath_p.md
MC_DATAPATH_P -- requirements
Module: mc_datapath_p

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, as the data, register and ALU width (legal range 8..64).
REQ-002 The block SHALL provide parameter NREG, default 16, as the number of architectural registers (legal range 2..16).
REQ-003 The block SHALL provide parameter AW, default 16, as the PC, instruction-address and data-address width.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  AW  fetch word address (equals pc).
REQ-008 imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 dmem_req  out  1  data access request.
REQ-011 dmem_we  out  1  1 = store, 0 = load; valid while dmem_req = 1.
REQ-012 dmem_addr  out  AW  data word address.
REQ-013 dmem_wdata  out  WIDTH  store data.
REQ-014 dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle.
REQ-015 dmem_rdata  in  WIDTH  load data.
REQ-016 dbg_sel  in  4  debug register index.
REQ-017 dbg_val  out  WIDTH  combinational read of register dbg_sel; 0 if dbg_sel >= NREG.
REQ-018 pc  out  AW  current program counter.
REQ-019 halted  out  1  high while in HALT.

Function
REQ-020 The instruction format SHALL be: op[31:26], rd[25:22], rs1[21:18], rs2[17:14], imm[13:0]; imm is sign-extended to WIDTH (branches and addresses use the low AW bits).
REQ-021 The opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR (rd = rs1 op rs2); 4 ADDI (rd = rs1 + imm); 5 LD (rd = mem[rs1+imm]); 6 ST (mem[rs1+imm] = rs2); 7 BEQ (if rs1 == rs2 then pc = pc+1+imm); 8 HALT; 9..63 NOP.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH and PC arithmetic modulo 2^AW (wrap, no flags).
REQ-023 Register 0 SHALL read as 0, and writes to it SHALL be discarded; reads of an index >= NREG SHALL return 0, and writes to such an index SHALL be discarded.
REQ-024 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-025 FETCH SHALL drive imem_req = 1 and imem_addr = pc, and SHALL remain in FETCH while imem_ack = 0; on an edge with imem_ack = 1 it SHALL latch IR and move to DECODE.
REQ-026 DECODE SHALL latch A = R[rs1], B = R[rs2] and IMM, then go to EXEC; for op 8 it SHALL go to HALT instead.
REQ-027 EXEC SHALL behave per opcode:
 - ALU ops and ADDI: latch ALUOUT, go to WB.
 - LD and ST: latch ALUOUT = A + IMM, go to MEM.
 - BEQ: pc <= pc+1+imm if A == B, else pc+1; go to FETCH.
 - NOP: pc <= pc+1; go to FETCH.
REQ-028 MEM SHALL drive dmem_req = 1, dmem_addr = ALUOUT[AW-1:0], dmem_we = (op == ST) and dmem_wdata = B, and SHALL remain in MEM while dmem_ack = 0.
REQ-029 On dmem_ack = 1 in MEM, ST SHALL set pc <= pc+1 and go to FETCH; LD SHALL latch LMD = dmem_rdata and go to WB.
REQ-030 WB SHALL write ALUOUT (or LMD for LD) to rd, set pc <= pc+1, and go to FETCH.
REQ-031 Request outputs SHALL hold address and data stable from assertion until the acknowledging edge, and SHALL be 0 in all other states.
REQ-032 With zero-wait memories, latency SHALL be: ALU/ADDI 4 cycles, LD 5, ST 4, BEQ/NOP 3; each ack wait cycle adds 1.
REQ-033 An ack arriving while the matching req = 0 SHALL be ignored.
REQ-034 HALT SHALL be absorbing: halted = 1, no requests issued, pc frozen, until rst.

Reset
REQ-035 While rst = 1 the block SHALL immediately force state FETCH, pc = 0, all registers, IR, A, B, IMM, ALUOUT and LMD = 0, halted = 0, imem_req = 0 and dmem_req = 0.
REQ-036 A reset asserted mid-access SHALL abandon the access, with no register or pc update.
REQ-037 After rst deasserts, the first imem_req SHALL occur in the first cycle with rst = 0.

Verification
REQ-038 Zero-wait memories; program ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT -> dbg r3 = 12, halted = 1, pc = 3, completed in 13 cycles.
REQ-039 ST r3 -> [r0+0x10], then LD r4 <- [r0+0x10], with dmem_ack delayed 3 cycles -> dmem_we = 1 then 0, address stable during each wait, r4 = 12, LD takes 8 cycles.
REQ-040 WIDTH = 8: ADDI r1,r0,-1 followed by ADDI r1,r1,2 -> r1 = 0x01 (wrap); ADDI r0,r0,9 -> r0 stays 0.
REQ-041 BEQ r1,r1,-1 at pc = 4 -> pc returns to 4 each iteration; BEQ with r1 != r2 -> pc = 5.
REQ-042 NREG = 4: write to r7 and dbg_sel = 7 -> dbg_val = 0, with no change to r0..r3.
REQ-043 rst pulsed while in MEM with LD pending, then dmem_ack = 1 -> no register write, pc = 0, and imem_req = 1 with imem_addr = 0 on the first cycle after release.
